// File: rtl/sia_work_dispatch.sv
// Work feeder for siacore: FIFO-buffers host jobs, issues them one at a time and reports found/timeout results.
// Optional statistics counters are compiled in with SIA_DISPATCH_STATS_EN.
module sia_work_dispatch #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [639:0] in_work,
    input  logic [63:0]  in_target,
    input  logic [7:0]   in_id,
    output logic [639:0] core_work,
    output logic [63:0]  core_target,
    output logic         core_valid,
    input  logic         core_found,
    input  logic [31:0]  core_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [7:0]   res_id,
    output logic [31:0]  res_nonce,
    output logic         res_found
`ifdef SIA_DISPATCH_STATS_EN
    ,
    output logic [31:0]  stat_jobs,
    output logic [31:0]  stat_timeouts,
    output logic [15:0]  stat_spurious
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 8 + 64 + 640;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_REPORT} state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [639:0]  work_q, work_d;
    logic [63:0]   target_q, target_d;
    logic [7:0]    job_id_q, job_id_d;
    logic [7:0]    res_id_q, res_id_d;
    logic [31:0]   res_nonce_q, res_nonce_d;
    logic          res_found_q, res_found_d;
    logic          push, pop;

    assign in_ready    = (count_q != FULL_CNT);
    assign core_valid  = (state_q == S_LOAD);
    assign res_valid   = (state_q == S_REPORT);
    assign core_work   = work_q;
    assign core_target = target_q;
    assign res_id      = res_id_q;
    assign res_nonce   = res_nonce_q;
    assign res_found   = res_found_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = (state_q == S_IDLE) && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_id, in_target, in_work};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        work_d      = work_q;
        target_d    = target_q;
        job_id_d    = job_id_q;
        res_id_d    = res_id_q;
        res_nonce_d = res_nonce_q;
        res_found_d = res_found_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {job_id_d, target_d, work_d} = mem_q[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturating timer; the timeout branch leaves WAIT before it could wrap.
                if (timer_q != T_LAST) timer_d = timer_q + 1'b1;
                if (core_found) begin
                    res_id_d    = job_id_q;
                    res_nonce_d = core_nonce;
                    res_found_d = 1'b1;
                    state_d     = S_REPORT;
                end else if (timer_q == T_LAST) begin
                    res_id_d    = job_id_q;
                    res_nonce_d = '0;
                    res_found_d = 1'b0;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            work_q      <= '0;
            target_q    <= '0;
            job_id_q    <= '0;
            res_id_q    <= '0;
            res_nonce_q <= '0;
            res_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            work_q      <= work_d;
            target_q    <= target_d;
            job_id_q    <= job_id_d;
            res_id_q    <= res_id_d;
            res_nonce_q <= res_nonce_d;
            res_found_q <= res_found_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef SIA_DISPATCH_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d;
    logic [31:0] stat_timeouts_q, stat_timeouts_d;
    logic [15:0] stat_spurious_q, stat_spurious_d;

    always_comb begin
        stat_jobs_d     = stat_jobs_q;
        stat_timeouts_d = stat_timeouts_q;
        stat_spurious_d = stat_spurious_q;
        if (res_valid && res_ready) begin
            if (stat_jobs_q != '1) stat_jobs_d = stat_jobs_q + 1'b1;
            if (!res_found_q && stat_timeouts_q != '1) stat_timeouts_d = stat_timeouts_q + 1'b1;
        end
        if (core_found && state_q != S_WAIT && stat_spurious_q != '1)
            stat_spurious_d = stat_spurious_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_jobs_q     <= '0;
            stat_timeouts_q <= '0;
            stat_spurious_q <= '0;
        end else begin
            stat_jobs_q     <= stat_jobs_d;
            stat_timeouts_q <= stat_timeouts_d;
            stat_spurious_q <= stat_spurious_d;
        end
    end

    assign stat_jobs     = stat_jobs_q;
    assign stat_timeouts = stat_timeouts_q;
    assign stat_spurious = stat_spurious_q;
`endif

endmodule

// File: tb/tb_sia_work_dispatch.sv
// Self-checking bench for sia_work_dispatch: directed table, corner sequences, randomized run vs transaction model.
module tb_sia_work_dispatch;
    localparam int DEPTH = 2;
    localparam int TO    = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [639:0] in_work;
    logic [63:0]  in_target;
    logic [7:0]   in_id;
    logic [639:0] core_work;
    logic [63:0]  core_target;
    logic         core_valid;
    logic         core_found;
    logic [31:0]  core_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   res_id;
    logic [31:0]  res_nonce;
    logic         res_found;
`ifdef SIA_DISPATCH_STATS_EN
    logic [31:0]  stat_jobs;
    logic [31:0]  stat_timeouts;
    logic [15:0]  stat_spurious;
`endif

    sia_work_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_work(in_work),
        .in_target(in_target), .in_id(in_id),
        .core_work(core_work), .core_target(core_target), .core_valid(core_valid),
        .core_found(core_found), .core_nonce(core_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_nonce(res_nonce), .res_found(res_found)
`ifdef SIA_DISPATCH_STATS_EN
        , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts), .stat_spurious(stat_spurious)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        int          k;          // WAIT cycle index that carries found; -1 = never
        logic [31:0] nonce;
        logic        exp_found;
        logic [31:0] exp_nonce;
        int          exp_lat;    // cycles from core_valid to first res_valid
    } vec_t;

    typedef struct packed {
        logic [7:0]   id;
        logic [63:0]  t;
        logic [639:0] w;
    } job_t;

    int checks = 0;
    int failures = 0;

    vec_t         tbl [5];
    job_t         q [$];
    job_t         cur, nj;
    logic [639:0] w, w67, last_work;
    logic [63:0]  last_target;
    logic [31:0]  pnonce;
    int           c, since, k, m_jobs, m_tos, m_spur;
    logic         active, push_p, pop_p, hs_p, exp_rv, legit, in_wait, bad_cv, bad_rv;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [639:0] rwork();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int resp_at(input int kk);
        return (kk < TO) ? kk + 2 : TO + 1;
    endfunction

    task automatic push_job(input logic [7:0] id, input logic [63:0] tg, input logic [639:0] wk);
        in_valid = 1'b1; in_id = id; in_target = tg; in_work = wk;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_work = '0; in_target = '0; in_id = '0;
        core_found = 1'b0; core_nonce = '0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_core_work", core_work, 0);
        chk("rst_core_target", core_target, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_nonce", res_nonce, 0);
        chk("rst_res_found", res_found, 0);

        // Single-job table: found early, never, first WAIT cycle, last WAIT cycle (beats timeout), one before.
        tbl[0] = '{8'h11,  5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF,  7};
        tbl[1] = '{8'h22, -1, 32'h00000000, 1'b0, 32'h00000000, 17};
        tbl[2] = '{8'h33,  0, 32'h12345678, 1'b1, 32'h12345678,  2};
        tbl[3] = '{8'h44, 15, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 17};
        tbl[4] = '{8'h55, 14, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 16};
        foreach (tbl[v]) begin
            w = rwork();
            push_job(tbl[v].id, 64'hFFFF, w);
            chk("tbl_cv_idle", core_valid, 0);
            tick();
            chk("tbl_cv_load", core_valid, 1);
            chk("tbl_core_work", core_work, w);
            chk("tbl_core_target", core_target, 64'hFFFF);
            c = 0;
            res_ready = 1'b1;
            while (!res_valid && c < 40) begin
                core_found = (tbl[v].k >= 0 && c == tbl[v].k + 1);
                core_nonce = core_found ? tbl[v].nonce : $urandom;
                tick();
                c++;
                core_found = 1'b0;
                chk("tbl_cv_once", core_valid, 0);
            end
            chk("tbl_latency", c, tbl[v].exp_lat);
            chk("tbl_res_id", res_id, tbl[v].id);
            chk("tbl_res_nonce", res_nonce, tbl[v].exp_nonce);
            chk("tbl_res_found", res_found, tbl[v].exp_found);
            tick();
            chk("tbl_res_drop", res_valid, 0);
        end

        // Result held under back-pressure while core_found toggles; a second job waits behind it.
        res_ready = 1'b0;
        w = rwork(); w67 = rwork();
        push_job(8'h66, 64'h1234, w);
        push_job(8'h67, 64'h5678, w67);
        chk("hold_cv_load", core_valid, 1);
        chk("hold_core_work", core_work, w);
        tick();
        core_found = 1'b1; core_nonce = 32'hA5A5_0066;
        tick();
        for (int i = 0; i < 20; i++) begin
            core_found = (i % 2 == 0);
            core_nonce = $urandom;
            tick();
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_id", res_id, 8'h66);
            chk("hold_res_nonce", res_nonce, 32'hA5A5_0066);
            chk("hold_res_found", res_found, 1);
            chk("hold_no_cv", core_valid, 0);
        end
        core_found = 1'b0;
`ifdef SIA_DISPATCH_STATS_EN
        chk("stat_jobs", stat_jobs, 5);
        chk("stat_timeouts", stat_timeouts, 1);
        chk("stat_spurious", stat_spurious, 10);
`endif
        res_ready = 1'b1;
        tick();
        chk("hold_release", res_valid, 0);
        chk("hold_idle_cv", core_valid, 0);
        push_job(8'h68, 64'h9ABC, rwork());
        chk("q_cv_load", core_valid, 1);
        chk("q_core_work", core_work, w67);
        chk("q_in_ready", in_ready, 1);
        tick(); tick(); tick();

        // Synchronous reset in WAIT with one job queued.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_core_work", core_work, 0);
        bad_cv = 1'b0; bad_rv = 1'b0;
        for (int i = 0; i < 25; i++) begin
            bad_cv |= core_valid;
            bad_rv |= res_valid;
            tick();
        end
        chk("mid_rst_no_cv", bad_cv, 0);
        chk("mid_rst_no_res", bad_rv, 0);

        // Randomized run against a transaction-level model.
        active = 1'b0; push_p = 1'b0; pop_p = 1'b0; hs_p = 1'b0;
        since = 0; k = 0; pnonce = '0;
        last_work = '0; last_target = '0;
        m_jobs = 0; m_tos = 0; m_spur = 0;
        nj = '0; cur = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hs_p) begin
                active = 1'b0;
                m_jobs++;
                if (k >= TO) m_tos++;
            end
            if (active) since++;
            if (pop_p) begin
                cur = q.pop_front();
                active = 1'b1; since = 0;
                k = $urandom_range(0, 19);
                pnonce = $urandom;
                last_work = cur.w; last_target = cur.t;
            end
            if (push_p) q.push_back(nj);

            exp_rv = active && since >= resp_at(k);
            chk("rnd_in_ready", in_ready, (q.size() < DEPTH));
            chk("rnd_core_valid", core_valid, pop_p);
            chk("rnd_core_work", core_work, last_work);
            chk("rnd_core_target", core_target, last_target);
            chk("rnd_res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                chk("rnd_res_id", res_id, cur.id);
                chk("rnd_res_found", res_found, (k < TO));
                chk("rnd_res_nonce", res_nonce, (k < TO) ? pnonce : 32'h0);
            end

            nj.id = 8'($urandom); nj.t = {$urandom, $urandom}; nj.w = rwork();
            in_valid  = (cyc < 2500) && ($urandom_range(0, 2) == 0);
            in_id     = nj.id; in_target = nj.t; in_work = nj.w;
            res_ready = $urandom_range(0, 1) == 1;
            legit   = active && k < TO && since == k + 1;
            in_wait = active && since >= 1 && since <= ((k < TO) ? k + 1 : TO);
            core_nonce = $urandom;
            core_found = 1'b0;
            if (legit) begin
                core_found = 1'b1;
                core_nonce = pnonce;
            end else if (!in_wait && $urandom_range(0, 3) == 0) begin
                core_found = 1'b1;
                m_spur++;
            end
            push_p = in_valid && (q.size() < DEPTH);
            pop_p  = !active && q.size() > 0;
            hs_p   = exp_rv && res_ready;
            tick();
        end
`ifdef SIA_DISPATCH_STATS_EN
        if (hs_p) begin
            m_jobs++;
            if (k >= TO) m_tos++;
        end
        chk("rnd_stat_jobs", stat_jobs, m_jobs);
        chk("rnd_stat_timeouts", stat_timeouts, m_tos);
        chk("rnd_stat_spurious", stat_spurious, m_spur);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
